// File: rtl/simon_pkg.sv
// Shared definitions for the Simon game: button count, button index type
// and a lowest-index helper used when several buttons fire together.
package simon_pkg;

    localparam int N_BTN = 4;

    typedef logic [1:0] btn_id_t;

    // Index of the lowest set bit; returns 0 for an all-zero vector.
    function automatic btn_id_t lowest_index(input logic [N_BTN-1:0] v);
        btn_id_t idx;
        idx = '0;
        for (int i = N_BTN - 1; i >= 0; i--) begin
            if (v[i]) begin
                idx = btn_id_t'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/simon_debounce.sv
// One button: 2-flop synchronizer, stability counter and debounced level.
// rise is a combinational look-ahead: high in the cycle whose edge raises level.
module simon_debounce #(
    parameter int DB_COUNT = 20000,
    parameter int DB_WIDTH = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ena,
    input  logic raw,
    output logic level,
    output logic rise
);

    logic                sync_q1;
    logic                sync_q2;
    logic [DB_WIDTH-1:0] cnt;
    logic                differs;
    logic                done;

    assign differs = (sync_q2 != level);
    assign done    = ena && differs && (cnt == DB_WIDTH'(DB_COUNT - 1));
    assign rise    = done && sync_q2;

    // The synchronizer keeps sampling while disabled so no stale value is
    // acted on when ena returns.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
        end else begin
            sync_q1 <= raw;
            sync_q2 <= sync_q1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            level <= 1'b0;
        end else if (ena) begin
            if (!differs) begin
                cnt <= '0;
            end else if (done) begin
                level <= sync_q2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/simon_button_input.sv
// Debounces the four colour buttons and turns debounced rising edges into a
// single-entry press event with a valid/ready handshake and an overrun flag.
module simon_button_input
    import simon_pkg::*;
#(
    parameter int DB_COUNT = 20000,
    parameter int DB_WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic             press_valid,
    output btn_id_t          press_id,
    input  logic             press_ready,
    output logic             overrun
);

    logic [N_BTN-1:0] rise;
    logic             consume;
    logic             multi;

    for (genvar i = 0; i < N_BTN; i++) begin : g_btn
        simon_debounce #(
            .DB_COUNT(DB_COUNT),
            .DB_WIDTH(DB_WIDTH)
        ) u_debounce (
            .clk  (clk),
            .rst_n(rst_n),
            .ena  (ena),
            .raw  (btn_raw[i]),
            .level(btn_level[i]),
            .rise (rise[i])
        );
    end

    // Handshake: an event transfers on a rising edge where press_valid and
    // press_ready are both high; until then press_valid/press_id hold steady.
    // press_ready with nothing pending is ignored.
    assign consume = press_valid && press_ready;
    // More than one bit set: clearing the lowest leaves something behind.
    assign multi   = |(rise & (rise - 1'b1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            press_valid <= 1'b0;
            press_id    <= '0;
            overrun     <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (|rise) begin
                if (!press_valid || consume) begin
                    press_valid <= 1'b1;
                    press_id    <= lowest_index(rise);
                    overrun     <= multi;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (consume) begin
                press_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_simon_button_input.sv
// Bench for simon_button_input: directed scenarios plus random button activity,
// all checked cycle by cycle against a behavioural model of the button rules.
module tb_simon_button_input;

    localparam int DB = 4;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [3:0] btn_raw;
    logic [3:0] btn_level;
    logic       press_valid;
    logic [1:0] press_id;
    logic       press_ready;
    logic       overrun;

    int n_tests = 0;
    int n_fail  = 0;

    // Model state: raw delayed by two samples, debounced level, count of
    // consecutive enabled samples disagreeing with the level, event register.
    logic [3:0] m_s1, m_s2, m_lvl;
    int         m_run[4];
    logic       m_pv;
    logic [1:0] m_pid;
    logic       m_ov;

    simon_button_input #(
        .DB_COUNT(DB),
        .DB_WIDTH(3)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .btn_raw    (btn_raw),
        .btn_level  (btn_level),
        .press_valid(press_valid),
        .press_id   (press_id),
        .press_ready(press_ready),
        .overrun    (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_s1 = '0; m_s2 = '0; m_lvl = '0;
        for (int i = 0; i < 4; i++) m_run[i] = 0;
        m_pv = 1'b0; m_pid = '0; m_ov = 1'b0;
    endtask

    task automatic model_update(input logic [3:0] raw, input logic e, input logic rdy);
        logic [3:0] rises;
        int         nrun;
        int         nev;
        int         first;
        logic       consume;
        rises = '0;
        if (e) begin
            for (int i = 0; i < 4; i++) begin
                nrun = (m_s2[i] != m_lvl[i]) ? m_run[i] + 1 : 0;
                if (nrun == DB) begin
                    if (m_s2[i]) rises[i] = 1'b1;
                    m_lvl[i] = m_s2[i];
                    nrun = 0;
                end
                m_run[i] = nrun;
            end
        end
        nev = 0;
        first = 0;
        for (int i = 3; i >= 0; i--) begin
            if (rises[i]) begin
                nev++;
                first = i;
            end
        end
        consume = m_pv && rdy;
        m_ov = 1'b0;
        if (nev > 0) begin
            if (!m_pv || consume) begin
                m_pv  = 1'b1;
                m_pid = 2'(first);
                m_ov  = (nev > 1);
            end else begin
                m_ov = 1'b1;
            end
        end else if (consume) begin
            m_pv = 1'b0;
        end
        m_s2 = m_s1;
        m_s1 = raw;
    endtask

    task automatic check_outputs();
        check_eq("btn_level", 32'(btn_level), 32'(m_lvl));
        check_eq("press_valid", 32'(press_valid), 32'(m_pv));
        if (m_pv) check_eq("press_id", 32'(press_id), 32'(m_pid));
        check_eq("overrun", 32'(overrun), 32'(m_ov));
    endtask

    // Called at a falling edge: drive inputs, advance the model over the
    // coming rising edge, then compare at the next falling edge.
    task automatic step(input logic [3:0] raw, input logic e, input logic rdy);
        btn_raw     = raw;
        ena         = e;
        press_ready = rdy;
        model_update(raw, e, rdy);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check_eq("rst_level", 32'(btn_level), 32'h0);
        check_eq("rst_valid", 32'(press_valid), 32'h0);
        check_eq("rst_id", 32'(press_id), 32'h0);
        check_eq("rst_overrun", 32'(overrun), 32'h0);
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [3:0] raw;
        logic       e;
        logic       rdy;
        rst_n = 1'b0;
        ena = 1'b1;
        btn_raw = '0;
        press_ready = 1'b0;
        @(negedge clk);
        do_reset();

        // Button 2 held: event appears at the sixth edge, not before.
        repeat (5) step(4'b0100, 1'b1, 1'b0);
        check_eq("b2_early_valid", 32'(press_valid), 32'h0);
        step(4'b0100, 1'b1, 1'b0);
        check_eq("b2_level", 32'(btn_level), 32'h4);
        check_eq("b2_valid", 32'(press_valid), 32'h1);
        check_eq("b2_id", 32'(press_id), 32'h2);
        check_eq("b2_overrun", 32'(overrun), 32'h0);

        // Short glitch on button 1 never reaches the level.
        do_reset();
        repeat (3) step(4'b0010, 1'b1, 1'b0);
        repeat (8) step(4'b0000, 1'b1, 1'b0);
        check_eq("glitch_level", 32'(btn_level), 32'h0);
        check_eq("glitch_valid", 32'(press_valid), 32'h0);

        // Buttons 3 and 0 together: lowest wins, one overrun pulse.
        do_reset();
        repeat (6) step(4'b1001, 1'b1, 1'b0);
        check_eq("dual_id", 32'(press_id), 32'h0);
        check_eq("dual_overrun", 32'(overrun), 32'h1);
        step(4'b1001, 1'b1, 1'b1);
        check_eq("dual_overrun_gone", 32'(overrun), 32'h0);
        check_eq("dual_consumed", 32'(press_valid), 32'h0);

        // Pending event, second button debounces without and with ready.
        do_reset();
        repeat (6) step(4'b0001, 1'b1, 1'b0);
        repeat (6) step(4'b0011, 1'b1, 1'b0);
        check_eq("drop_overrun", 32'(overrun), 32'h1);
        check_eq("drop_id", 32'(press_id), 32'h0);
        repeat (6) step(4'b0111, 1'b1, 1'b0);
        step(4'b0111, 1'b1, 1'b0);
        step(4'b0111, 1'b1, 1'b0);
        do_reset();
        repeat (6) step(4'b0001, 1'b1, 1'b0);
        repeat (5) step(4'b0101, 1'b1, 1'b0);
        step(4'b0101, 1'b1, 1'b1);
        check_eq("reload_id", 32'(press_id), 32'h2);
        check_eq("reload_valid", 32'(press_valid), 32'h1);
        check_eq("reload_overrun", 32'(overrun), 32'h0);

        // Disabled: held press is frozen, then completes DB edges after ena.
        do_reset();
        repeat (20) step(4'b0100, 1'b0, 1'b0);
        check_eq("ena0_level", 32'(btn_level), 32'h0);
        check_eq("ena0_valid", 32'(press_valid), 32'h0);
        repeat (DB) step(4'b0100, 1'b1, 1'b0);
        check_eq("ena1_valid", 32'(press_valid), 32'h1);

        // Reset mid-debounce with an event pending.
        do_reset();
        repeat (6) step(4'b0001, 1'b1, 1'b0);
        repeat (4) step(4'b0011, 1'b1, 1'b0);
        do_reset();
        repeat (5) step(4'b0011, 1'b1, 1'b0);
        check_eq("post_rst_early", 32'(press_valid), 32'h0);
        step(4'b0011, 1'b1, 1'b0);
        check_eq("post_rst_valid", 32'(press_valid), 32'h1);

        // Random activity.
        do_reset();
        raw = '0;
        for (int c = 0; c < 4000; c++) begin
            for (int i = 0; i < 4; i++) begin
                if ($urandom_range(0, 11) == 0) raw[i] = ~raw[i];
            end
            e   = ($urandom_range(0, 9) != 0);
            rdy = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 599) == 0) begin
                do_reset();
            end else begin
                step(raw, e, rdy);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
